// File: rtl/interrupt_priority_arbiter.sv
// Registered max-priority interrupt resolver with claim/complete in-service tracking; 1-cycle input-to-output latency.
// Define IPA_EDGE_TRIG_EN to add per-source edge-triggered pending latches (edge_mode port).
module interrupt_priority_arbiter #(
   parameter int N_INTERRUPTS = 32,
   parameter int PRIO_W       = 3,
   parameter int ID_W         = $clog2(N_INTERRUPTS + 1)
) (
   input  logic                             clk,
   input  logic                             n_rst,
   input  logic [N_INTERRUPTS*PRIO_W-1:0]   interrupt_priorities,
   input  logic [N_INTERRUPTS-1:0]          pending_interrupts,
   input  logic [N_INTERRUPTS-1:0]          interrupt_enable,
`ifdef IPA_EDGE_TRIG_EN
   input  logic [N_INTERRUPTS-1:0]          edge_mode,
`endif
   input  logic [PRIO_W-1:0]                threshold,
   input  logic                             claim_i,
   input  logic                             complete_i,
   input  logic [ID_W-1:0]                  complete_id_i,
   output logic [ID_W-1:0]                  claim_id_o,
   output logic [PRIO_W-1:0]                active_prio_o,
   output logic                             irq_o,
   output logic                             irq_rise_o,
   output logic [N_INTERRUPTS-1:0]          in_service_o
);

   localparam int LEVELS = $clog2(N_INTERRUPTS);
   localparam int LEAVES = 1 << LEVELS;

   logic [PRIO_W-1:0]       src_prio [N_INTERRUPTS];
   logic [N_INTERRUPTS-1:0] claim_hit;
   logic [N_INTERRUPTS-1:0] complete_hit;
   logic [N_INTERRUPTS-1:0] in_service_next;
   logic [N_INTERRUPTS-1:0] eff_pending;
   logic [N_INTERRUPTS-1:0] eligible;
   logic [PRIO_W-1:0]       tree_prio [LEAVES];
   logic [ID_W-1:0]         tree_id   [LEAVES];
   logic                    irq_prev;

   // Set beats clear, so a same-ID claim+complete leaves the source in service.
   always_comb begin
      for (int i = 0; i < N_INTERRUPTS; i++) begin
         src_prio[i]     = interrupt_priorities[i*PRIO_W +: PRIO_W];
         claim_hit[i]    = claim_i && (claim_id_o == ID_W'(i + 1));
         complete_hit[i] = complete_i && (complete_id_i == ID_W'(i + 1));
      end
      in_service_next = (in_service_o & ~complete_hit) | claim_hit;
   end

`ifdef IPA_EDGE_TRIG_EN
   logic [N_INTERRUPTS-1:0] pend_q;
   logic [N_INTERRUPTS-1:0] pend_latch;
   logic [N_INTERRUPTS-1:0] pend_rise;

   assign pend_rise   = pending_interrupts & ~pend_q & edge_mode;
   assign eff_pending = (edge_mode & (pend_latch | pend_rise)) | (~edge_mode & pending_interrupts);

   // A new edge outranks the claim clear, so an edge coinciding with its claim stays latched.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         pend_q     <= '0;
         pend_latch <= '0;
      end else begin
         pend_q     <= pending_interrupts;
         pend_latch <= (pend_latch & ~claim_hit) | pend_rise;
      end
   end
`else
   assign eff_pending = pending_interrupts;
`endif

   always_comb begin
      for (int i = 0; i < N_INTERRUPTS; i++) begin
         eligible[i] = eff_pending[i] & interrupt_enable[i] & ~in_service_next[i]
                     & (src_prio[i] > threshold);
      end
   end

   // Comparator tree reduced in place; ">=" keeps the lower-index child so ties go to the lowest ID.
   always_comb begin
      for (int i = 0; i < LEAVES; i++) begin
         tree_prio[i] = '0;
         tree_id[i]   = '0;
      end
      for (int i = 0; i < N_INTERRUPTS; i++) begin
         if (eligible[i]) begin
            tree_prio[i] = src_prio[i];
            tree_id[i]   = ID_W'(i + 1);
         end
      end
      for (int lvl = LEVELS - 1; lvl >= 0; lvl--) begin
         for (int j = 0; j < (1 << lvl); j++) begin
            if (tree_prio[2*j] >= tree_prio[2*j+1]) begin
               tree_prio[j] = tree_prio[2*j];
               tree_id[j]   = tree_id[2*j];
            end else begin
               tree_prio[j] = tree_prio[2*j+1];
               tree_id[j]   = tree_id[2*j+1];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         claim_id_o    <= '0;
         active_prio_o <= '0;
         irq_o         <= 1'b0;
         irq_prev      <= 1'b0;
         in_service_o  <= '0;
      end else begin
         claim_id_o    <= tree_id[0];
         active_prio_o <= tree_prio[0];
         irq_o         <= (tree_id[0] != '0);
         irq_prev      <= irq_o;
         in_service_o  <= in_service_next;
      end
   end

   assign irq_rise_o = irq_o & ~irq_prev;

endmodule

// File: tb/tb_interrupt_priority_arbiter.sv
// Scoreboard bench for interrupt_priority_arbiter: a behavioural model predicts each cycle's outputs.
module tb_interrupt_priority_arbiter;
   localparam int N  = 32;
   localparam int PW = 3;
   localparam int IW = 6;

   logic            clk = 1'b0;
   logic            n_rst;
   logic [N*PW-1:0] prios;
   logic [N-1:0]    pend;
   logic [N-1:0]    en;
   logic [PW-1:0]   thr;
   logic            claim;
   logic            complete;
   logic [IW-1:0]   cid;
   logic [IW-1:0]   claim_id;
   logic [PW-1:0]   active_prio;
   logic            irq;
   logic            irq_rise;
   logic [N-1:0]    in_service;
`ifdef IPA_EDGE_TRIG_EN
   logic [N-1:0]    edge_mode;
`endif

   always #5 clk = ~clk;

   interrupt_priority_arbiter #(.N_INTERRUPTS(N), .PRIO_W(PW), .ID_W(IW)) dut (
      .clk                  (clk),
      .n_rst                (n_rst),
      .interrupt_priorities (prios),
      .pending_interrupts   (pend),
      .interrupt_enable     (en),
`ifdef IPA_EDGE_TRIG_EN
      .edge_mode            (edge_mode),
`endif
      .threshold            (thr),
      .claim_i              (claim),
      .complete_i           (complete),
      .complete_id_i        (cid),
      .claim_id_o           (claim_id),
      .active_prio_o        (active_prio),
      .irq_o                (irq),
      .irq_rise_o           (irq_rise),
      .in_service_o         (in_service)
   );

   typedef struct {
      logic [IW-1:0] id;
      logic [PW-1:0] prio;
      logic          irq;
      logic          rise;
      logic [N-1:0]  isv;
   } exp_t;

   exp_t         sb[$];
   int           errors = 0;
   int           checks = 0;
   logic [IW-1:0] m_id;
   logic          m_irq;
   logic [N-1:0]  m_isv;
   logic [N-1:0]  m_latch;
   logic [N-1:0]  m_pq;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_prio(input int id, input int p);
      prios[(id-1)*PW +: PW] = PW'(p);
   endtask

   // Predict the outputs that follow the next clock edge from the inputs now being driven.
   task automatic model_step();
      logic [N-1:0]  ns;
      logic [N-1:0]  eff;
      logic [N-1:0]  hit;
      logic [PW-1:0] bp;
      logic [PW-1:0] p;
      logic [IW-1:0] bid;
      exp_t          e;
      ns  = m_isv;
      hit = '0;
      if (complete && cid >= 1 && int'(cid) <= N) ns[int'(cid)-1] = 1'b0;
      if (claim && m_id != 0) begin
         ns[int'(m_id)-1]  = 1'b1;
         hit[int'(m_id)-1] = 1'b1;
      end
      eff = pend;
`ifdef IPA_EDGE_TRIG_EN
      begin
         logic [N-1:0] rise;
         rise = pend & ~m_pq & edge_mode;
         for (int i = 0; i < N; i++) if (edge_mode[i]) eff[i] = m_latch[i] | rise[i];
         m_latch = (m_latch & ~hit) | rise;
         m_pq    = pend;
      end
`endif
      bp  = '0;
      bid = '0;
      for (int i = 0; i < N; i++) begin
         p = prios[i*PW +: PW];
         if (eff[i] && en[i] && !ns[i] && p > thr && p > bp) begin
            bp  = p;
            bid = IW'(i + 1);
         end
      end
      e.id   = bid;
      e.prio = bp;
      e.irq  = (bid != 0);
      e.rise = (bid != 0) && !m_irq;
      e.isv  = ns;
      m_id   = bid;
      m_irq  = (bid != 0);
      m_isv  = ns;
      sb.push_back(e);
   endtask

   task automatic cycle();
      exp_t e;
      model_step();
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("sb_underflow", 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         check("claim_id", claim_id, e.id);
         check("active_prio", active_prio, e.prio);
         check("irq", irq, e.irq);
         check("irq_rise", irq_rise, e.rise);
         check("in_service", in_service, e.isv);
      end
   endtask

   task automatic do_reset();
      pend = '0; en = '0; thr = '0; prios = '0;
      claim = 0; complete = 0; cid = '0;
`ifdef IPA_EDGE_TRIG_EN
      edge_mode = '0;
`endif
      m_id = '0; m_irq = 0; m_isv = '0; m_latch = '0; m_pq = '0;
      n_rst = 0;
      #3;
      check("rst_claim_id", claim_id, 0);
      check("rst_prio", active_prio, 0);
      check("rst_irq", irq, 0);
      check("rst_rise", irq_rise, 0);
      check("rst_isv", in_service, 0);
      @(posedge clk);
      #1;
      n_rst = 1;
   endtask

   initial begin
      n_rst = 1;
      #2;
      do_reset();

      // Highest priority wins, irq_rise pulses once.
      en = '1;
      set_prio(1, 2); set_prio(3, 5);
      pend = 32'h5;
      cycle();
      check("s1_id", claim_id, 3);
      check("s1_prio", active_prio, 5);
      check("s1_rise", irq_rise, 1);
      cycle();
      check("s1_rise_once", irq_rise, 0);

      // Tie goes to the lower ID; claim reveals the other.
      pend = '0; cycle();
      set_prio(2, 4); set_prio(7, 4);
      pend = 32'h42;
      cycle();
      check("s2_tie", claim_id, 2);
      claim = 1; cycle(); claim = 0;
      check("s2_next", claim_id, 7);
      check("s2_isv", in_service, 32'h2);
      complete = 1; cid = 2; cycle(); complete = 0;

      // Threshold is strict.
      pend = 32'h40; thr = 4; cycle();
      check("s3_thr_block", irq, 0);
      thr = 3; cycle();
      check("s3_thr_pass", claim_id, 7);
      thr = 0;

      // Claim / complete including out-of-range completes.
      pend = 32'h4; cycle();
      claim = 1; cycle(); claim = 0;
      check("s4_claimed", claim_id, 0);
      cycle();
      complete = 1; cid = 0; cycle();
      cid = IW'(N + 1); cycle();
      check("s4_bad_cid", in_service, 32'h4);
      cid = 3; cycle(); complete = 0;
      check("s4_reappear", claim_id, 3);

      // Simultaneous claim and complete.
      set_prio(5, 6);
      pend = 32'h2; cycle();
      claim = 1; cycle(); claim = 0;
      pend = 32'h12; cycle();
      check("s5_win5", claim_id, 5);
      claim = 1; complete = 1; cid = 2; cycle();
      check("s5_isv", in_service, 32'h10);
      check("s5_id2", claim_id, 2);
      cycle();
      claim = 0; complete = 0;
      check("s5_same_id", in_service, 32'h12);
      complete = 1; cid = 5; cycle(); complete = 0;
      pend = 32'h2; claim = 1; cycle(); claim = 0;
      check("s5_drop_claim", in_service, 32'h12);
      check("s5_drop_id", claim_id, 0);

      // Random traffic.
      for (int k = 0; k < 400; k++) begin
         pend     = $urandom();
         en       = $urandom() | $urandom();
         thr      = PW'($urandom_range(0, 3));
         claim    = ($urandom_range(0, 2) == 0);
         complete = ($urandom_range(0, 1) == 0);
         cid      = IW'($urandom_range(0, N + 2));
         if (k % 16 == 0) for (int i = 1; i <= N; i++) set_prio(i, $urandom_range(0, 7));
`ifdef IPA_EDGE_TRIG_EN
         edge_mode = $urandom();
`endif
         cycle();
      end
      claim = 0; complete = 0;

`ifdef IPA_EDGE_TRIG_EN
      do_reset();
      en = '1; edge_mode = 32'h1; set_prio(1, 3);
      pend = 32'h1; cycle();
      pend = 32'h0; cycle(); cycle();
      check("e_persist", claim_id, 1);
      claim = 1; cycle(); claim = 0;
      check("e_claimed", claim_id, 0);
      pend = 32'h1; cycle();
      pend = 32'h0; cycle();
      complete = 1; cid = 1; cycle(); complete = 0;
      check("e_rewin", claim_id, 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
